// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage register with a 2-entry skid buffer (strict FIFO order).
// Latency: one cycle minimum; an entry pushed into an empty stage is on out_* after the next edge.
// Backpressure: in_ready comes only from registered state and drops while both slots are full.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready MEM-side handshake; in_wreg/in_data/in_ctrl carry the entry
//   flush             synchronous discard of every held entry (beats push and pop)
//   out_valid/out_ready WB-side handshake; out_wreg/out_data/out_ctrl show the head entry
//   occupancy         number of entries held (0, 1 or 2)
module mem_wb_stage #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_wreg,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_wreg,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state;

  logic [REG_AW-1:0] head_wreg;
  logic [DATA_W-1:0] head_data;
  logic [CTRL_W-1:0] head_ctrl;
  logic [REG_AW-1:0] skid_wreg;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  logic push;
  logic pop;

  // Both handshake outputs are decoded from the state register alone, so no
  // input ever reaches in_ready or out_valid combinationally.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign out_wreg = head_wreg;
  assign out_data = head_data;
  // An empty head must never present a write enable to the register file.
  assign out_ctrl = out_valid ? head_ctrl : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      head_wreg <= '0;
      head_data <= '0;
      head_ctrl <= '0;
      skid_wreg <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      // Payload is left stale; only the state decides what is visible.
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head_wreg <= in_wreg;
            head_data <= in_data;
            head_ctrl <= in_ctrl;
            state     <= ONE;
          end
        end
        ONE: begin
          if (push && !pop) begin
            // Head is stalled; park the newcomer behind it.
            skid_wreg <= in_wreg;
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
            state     <= TWO;
          end else if (push && pop) begin
            head_wreg <= in_wreg;
            head_data <= in_data;
            head_ctrl <= in_ctrl;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            head_wreg <= skid_wreg;
            head_data <= skid_data;
            head_ctrl <= skid_ctrl;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus random traffic against a queue model.
// Latency: checks outputs one time unit after each rising edge.
// Backpressure: the model accepts a push only while it holds fewer than two entries.
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_wreg;
  logic [63:0] in_data;
  logic [1:0]  in_ctrl;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_wreg;
  logic [63:0] out_data;
  logic [1:0]  out_ctrl;
  logic [1:0]  occupancy;

  // Second instance with non-default widths
  logic        w_in_valid;
  logic        w_in_ready;
  logic [5:0]  w_in_wreg;
  logic [31:0] w_in_data;
  logic [2:0]  w_in_ctrl;
  logic        w_flush;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [5:0]  w_out_wreg;
  logic [31:0] w_out_data;
  logic [2:0]  w_out_ctrl;
  logic [1:0]  w_occupancy;

  int vectors;
  int miscompares;

  typedef struct {
    logic [4:0]  wreg;
    logic [63:0] data;
    logic [1:0]  ctrl;
  } ent_t;

  ent_t q[$];

  mem_wb_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wreg(in_wreg), .in_data(in_data), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wreg(out_wreg), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  mem_wb_stage #(.DATA_W(32), .REG_AW(6), .CTRL_W(3)) dut_w (
    .clk(clk), .reset(reset),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_wreg(w_in_wreg), .in_data(w_in_data), .in_ctrl(w_in_ctrl),
    .flush(w_flush),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_wreg(w_out_wreg), .out_data(w_out_data), .out_ctrl(w_out_ctrl),
    .occupancy(w_occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the queue model.
  task automatic check_outputs();
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_wreg", 64'(out_wreg), 64'(q[0].wreg));
      chk("out_data", out_data, q[0].data);
      chk("out_ctrl", 64'(out_ctrl), 64'(q[0].ctrl));
    end else begin
      chk("out_ctrl_gated", 64'(out_ctrl), 64'd0);
    end
  endtask

  // One clock cycle: apply inputs, check current outputs, advance the model at the edge.
  task automatic step(input logic iv, input logic [4:0] w, input logic [63:0] d,
                      input logic [1:0] c, input logic ordy, input logic fl);
    bit do_push;
    bit do_pop;
    ent_t e;
    in_valid  = iv;
    in_wreg   = w;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    check_outputs();
    do_push = iv && (q.size() < 2);
    do_pop  = ordy && (q.size() != 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.wreg = w;
        e.data = d;
        e.ctrl = c;
        q.push_back(e);
      end
    end
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    in_valid    = 1'b0;
    in_wreg     = '0;
    in_data     = '0;
    in_ctrl     = '0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    w_in_valid  = 1'b0;
    w_in_wreg   = '0;
    w_in_data   = '0;
    w_in_ctrl   = '0;
    w_flush     = 1'b0;
    w_out_ready = 1'b0;

    // Power-on reset, checked before any clock edge
    #1 reset = 1'b1;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_out_wreg", 64'(out_wreg), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_w_out_data", 64'(w_out_data), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Streaming: wreg 1..8, data 0x10..0x80, one per cycle with out_ready high
    for (int i = 1; i <= 8; i++)
      step(1'b1, 5'(i), 64'(i * 16), 2'b01, 1'b1, 1'b0);
    step(1'b0, 5'd0, 64'd0, 2'b00, 1'b1, 1'b0);
    step(1'b0, 5'd0, 64'd0, 2'b00, 1'b1, 1'b0);

    // Backpressure: fill with A then B, then drain
    step(1'b1, 5'd3, 64'hAAAA, 2'b01, 1'b0, 1'b0);
    step(1'b1, 5'd4, 64'hBBBB, 2'b11, 1'b0, 1'b0);
    step(1'b1, 5'd9, 64'h9999, 2'b01, 1'b0, 1'b0);  // refused while full
    step(1'b0, 5'd0, 64'd0, 2'b00, 1'b1, 1'b0);
    step(1'b0, 5'd0, 64'd0, 2'b00, 1'b1, 1'b0);
    step(1'b0, 5'd0, 64'd0, 2'b00, 1'b1, 1'b0);

    // Simultaneous push and pop while holding one entry
    step(1'b1, 5'd12, 64'hCCCC, 2'b01, 1'b0, 1'b0);
    step(1'b1, 5'd13, 64'hDDDD, 2'b10, 1'b1, 1'b0);
    step(1'b0, 5'd0, 64'd0, 2'b00, 1'b1, 1'b0);
    step(1'b0, 5'd0, 64'd0, 2'b00, 1'b1, 1'b0);

    // Flush while full, with an incoming entry and a pop in the same cycle
    step(1'b1, 5'd20, 64'h2020, 2'b01, 1'b0, 1'b0);
    step(1'b1, 5'd21, 64'h2121, 2'b01, 1'b0, 1'b0);
    step(1'b1, 5'd22, 64'h2222, 2'b01, 1'b1, 1'b1);
    step(1'b0, 5'd0, 64'd0, 2'b00, 1'b1, 1'b0);
    step(1'b1, 5'd23, 64'h2323, 2'b01, 1'b1, 1'b0);
    step(1'b0, 5'd0, 64'd0, 2'b00, 1'b1, 1'b0);

    // Reset mid-cycle with the stage full: outputs clear without a clock edge
    step(1'b1, 5'd30, 64'h3030, 2'b01, 1'b0, 1'b0);
    step(1'b1, 5'd31, 64'h3131, 2'b01, 1'b0, 1'b0);
    chk("pre_rst_occupancy", 64'(occupancy), 64'd2);
    #2 reset = 1'b1;
    #1;
    q.delete();
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    chk("midrst_out_wreg", 64'(out_wreg), 64'd0);
    chk("midrst_occupancy", 64'(occupancy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    // Nothing is captured while reset is held
    in_valid = 1'b1;
    in_wreg  = 5'd7;
    in_data  = 64'h7777;
    @(posedge clk);
    #1;
    chk("rst_hold_occupancy", 64'(occupancy), 64'd0);
    chk("rst_hold_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    step(1'b1, 5'd8, 64'h8888, 2'b01, 1'b1, 1'b0);
    step(1'b0, 5'd0, 64'd0, 2'b00, 1'b1, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 5'($urandom), {$urandom, $urandom}, 2'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    step(1'b0, 5'd0, 64'd0, 2'b00, 1'b1, 1'b0);
    step(1'b0, 5'd0, 64'd0, 2'b00, 1'b1, 1'b0);
    step(1'b0, 5'd0, 64'd0, 2'b00, 1'b1, 1'b0);

    // Non-default widths pass unmodified
    w_in_valid  = 1'b1;
    w_in_wreg   = 6'h3F;
    w_in_data   = 32'hDEADBEEF;
    w_in_ctrl   = 3'b101;
    w_out_ready = 1'b0;
    @(posedge clk);
    #1;
    w_in_valid = 1'b0;
    chk("w_out_valid", 64'(w_out_valid), 64'd1);
    chk("w_out_wreg", 64'(w_out_wreg), 64'h3F);
    chk("w_out_data", 64'(w_out_data), 64'hDEADBEEF);
    chk("w_out_ctrl", 64'(w_out_ctrl), 64'h5);
    chk("w_occupancy", 64'(w_occupancy), 64'd1);
    w_out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("w_pop_out_valid", 64'(w_out_valid), 64'd0);
    chk("w_pop_out_ctrl", 64'(w_out_ctrl), 64'd0);
    chk("w_pop_occupancy", 64'(w_occupancy), 64'd0);
    chk("w_pop_in_ready", 64'(w_in_ready), 64'd1);
    chk("w_pop_data_held", 64'(w_out_data), 64'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Parametrised MEM->WB pipeline stage register with a valid/ready handshake and a 2-entry skid buffer. Decouples writeback backpressure from the MEM stage without a combinational ready path. Adds synchronous flush and control gating so an empty slot can never assert a writeback enable. Sits between the data-memory stage and the register-file write port of the five-stage pipe.

Parameters:
DATA_W, 64, width of the ALU/memory result field
REG_AW, 5, width of the destination register address
CTRL_W, 2, width of the writeback control field (bit 0 = register write enable, bit 1 = mem-to-reg select)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  MEM stage presents an entry
in_ready  output  1  stage can accept an entry; registered, no combinational input dependency
in_wreg  input  REG_AW  destination register
in_data  input  DATA_W  result data
in_ctrl  input  CTRL_W  writeback control
flush  input  1  synchronous discard of all held entries
out_valid  output  1  head entry valid toward WB
out_ready  input  1  WB consumes the head entry
out_wreg  output  REG_AW  head destination register
out_data  output  DATA_W  head data
out_ctrl  output  CTRL_W  head control; forced to 0 when out_valid=0
occupancy  output  2  entries held: 0, 1 or 2

Behaviour:
- Storage: head register (drives out_*) and skid register. Order is strict FIFO.
- push = in_valid & in_ready; pop = out_valid & out_ready; both sampled on the rising edge of clk.
- States: EMPTY (occ 0), ONE (occ 1, head valid), TWO (occ 2, head and skid valid).
- EMPTY: push -> ONE, head <= in. No push -> stay.
- ONE: push & !pop -> TWO, skid <= in. push & pop -> ONE, head <= in. !push & pop -> EMPTY. Neither -> stay.
- TWO: in_ready=0, so push cannot occur. pop -> ONE, head <= skid. No pop -> stay, all registers hold.
- in_ready = (state != TWO), driven from a registered state only.
- out_valid = (state != EMPTY). occupancy equals the state encoding.
- Latency: an entry pushed at edge N appears on out_* after edge N if the stage was empty, or if in ONE with a simultaneous pop. Minimum one cycle.
- Throughput: one entry per cycle while out_ready=1.
- Gating: out_ctrl = head_ctrl when out_valid=1, else 0. out_wreg and out_data hold their last value when invalid and are don't-care.
- Flush: at the edge where flush=1, state -> EMPTY. Any push or pop in that cycle is discarded. Payload registers may hold stale values. Flush has priority over every other event.
- Reset, asserted at any time (including mid-transfer): immediately clears state to EMPTY and all payload registers to 0.
  - Reset values: out_valid=0, out_ctrl=0, out_wreg=0, out_data=0, occupancy=0, in_ready=1.
  - in_ready is also 1 while reset is held.
  - Deassertion takes effect at the next clk edge; no entry is captured while reset=1.
- Payload widths are exact. No sign-extension or truncation; fields pass unmodified.

Test Plan:
- Reset: assert reset mid-cycle with the stage in TWO -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1 immediately, without a clock edge.
- Streaming: out_ready=1, push entries (wreg=1..8, data=0x10..0x80, ctrl=2'b01) one per cycle -> each appears one cycle later in order, occupancy stays 1, in_ready stays 1.
- Backpressure: out_ready=0, push A (wreg=3, data=0xAAAA) then B (wreg=4, data=0xBBBB) -> occupancy 2, in_ready=0, head shows A. Raise out_ready -> A then B pop on consecutive cycles, then out_valid=0 and out_ctrl=0.
- Simultaneous push and pop in ONE: head=C, push D with out_ready=1 -> next cycle head=D, occupancy=1, no entry lost or duplicated.
- Flush: in TWO, assert flush together with in_valid=1 and out_ready=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready=1; neither the flushed entries nor the incoming entry ever appear on out_*.
- Width parametrisation: DATA_W=32, REG_AW=6, CTRL_W=3, push data=0xDEADBEEF, wreg=6'h3F, ctrl=3'b101 -> identical values on out_*, and out_ctrl=0 after the pop empties the stage.
